// File: rtl/xnor_bist_ctrl.sv
// rtl/xnor_bist_ctrl.sv - self-test sequencer for a 2-input xnor gate
// Optional first-error capture: define XNOR_BIST_ERR_CAPTURE_EN.
module xnor_bist_ctrl #(
  parameter int         SETTLE_CYC = 2,
  parameter logic [3:0] TRUTH      = 4'b1001,
  parameter int         LOOPS      = 1,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt
`ifdef XNOR_BIST_ERR_CAPTURE_EN
  ,
  output logic [1:0]       first_err_vec,
  output logic             first_err_vld
`endif
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    vec;
  logic [LW-1:0] loop_cnt;
  logic [SW-1:0] set_cnt;
  logic          mismatch;
  logic          last_vec;
  logic          settle_end;

  assign mismatch   = (y_i != TRUTH[vec]);
  assign last_vec   = (vec == 2'd3) && (loop_cnt == LW'(LOOPS - 1));
  assign settle_end = (set_cnt == SW'(SETTLE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_end) state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= 2'd0;
      loop_cnt <= '0;
      set_cnt  <= '0;
      err_cnt  <= '0;
      pass     <= 1'b0;
`ifdef XNOR_BIST_ERR_CAPTURE_EN
      first_err_vec <= 2'd0;
      first_err_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec      <= 2'd0;
            loop_cnt <= '0;
            set_cnt  <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
`ifdef XNOR_BIST_ERR_CAPTURE_EN
            first_err_vec <= 2'd0;
            first_err_vld <= 1'b0;
`endif
          end
        end
        SETTLE: set_cnt <= settle_end ? '0 : set_cnt + 1'b1;
        CHECK: begin
          if (mismatch && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
`ifdef XNOR_BIST_ERR_CAPTURE_EN
          if (mismatch && !first_err_vld) begin
            first_err_vec <= vec;
            first_err_vld <= 1'b1;
          end
`endif
          // Pass must reflect the mismatch being counted in this same cycle.
          if (last_vec) begin
            pass <= (err_cnt == '0) && !mismatch;
          end else begin
            vec <= vec + 2'd1;
            if (vec == 2'd3) loop_cnt <= loop_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign a_o  = busy & vec[1];
  assign b_o  = busy & vec[0];

endmodule
